// File: rtl/de10_lite_key_evt_pkg.sv
// Shared types and PIO register offsets for the DE10-Lite key event master.
package de10_lite_key_evt_pkg;

  typedef enum logic [3:0] {
    StInitMask,
    StInitClr,
    StIdle,
    StRdCap,
    StClr,
    StRdLvl,
    StLvlSmp,
    StEmit,
    StHoldoff,
    StHoClr
  } key_evt_state_e;

  localparam logic [1:0] KEY_OFS_DATA = 2'd0;
  localparam logic [1:0] KEY_OFS_MASK = 2'd2;
  localparam logic [1:0] KEY_OFS_EDGE = 2'd3;

endpackage

// File: rtl/de10_lite_key_holdoff_timer.sv
// Debounce hold-off down-counter: start loads CYCLES-1, done flags the final cycle.
module de10_lite_key_holdoff_timer #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic done
);

  localparam int unsigned Load = (CYCLES > 0) ? CYCLES - 1 : 0;
  localparam int unsigned CntW = (Load > 1) ? $clog2(Load + 1) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CntW'(Load);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Counter sits at Load in the first hold-off cycle, so done spans CYCLES cycles.
  assign done = (cnt_q == '0);

endmodule

// File: rtl/de10_lite_key_event_master.sv
// Avalon-MM initiator servicing the key PIO; emits coalesced key events on a valid/ready stream.
// Define KEY_EVT_HOLDOFF_EN to add the post-event debounce hold-off and edge discard.
module de10_lite_key_event_master
  import de10_lite_key_evt_pkg::*;
#(
  parameter int unsigned         KEY_W          = 4,
  parameter logic [KEY_W-1:0]    IRQ_MASK       = 4'hF,
  parameter int unsigned         HOLDOFF_CYCLES = 500000,
  parameter int unsigned         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  input  logic             irq,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [KEY_W-1:0] event_keys,
  output logic [KEY_W-1:0] event_level,
  output logic [CNT_W-1:0] event_count
);

  key_evt_state_e   state_q, state_d;
  logic [KEY_W-1:0] cap_q, lvl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  logic unused_rd;
  assign unused_rd = ^readdata[31:KEY_W];

`ifdef KEY_EVT_HOLDOFF_EN
  logic ho_start, ho_done;

  de10_lite_key_holdoff_timer #(
    .CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (ho_start),
    .done   (ho_done)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^HOLDOFF_CYCLES;
`endif

  assign accept = (state_q == StEmit) && event_ready;

  always_comb begin
    state_d = state_q;
`ifdef KEY_EVT_HOLDOFF_EN
    ho_start = 1'b0;
`endif
    case (state_q)
      StInitMask: state_d = StInitClr;
      StInitClr:  state_d = StIdle;
      StIdle:     if (irq) state_d = StRdCap;
      StRdCap:    state_d = StClr;
      StClr:      state_d = StRdLvl;
      StRdLvl:    state_d = StLvlSmp;
      // An irq with nothing unmasked captured is dropped without an event.
      StLvlSmp:   state_d = (cap_q == '0) ? StIdle : StEmit;
      StEmit: begin
        if (event_ready) begin
`ifdef KEY_EVT_HOLDOFF_EN
          ho_start = 1'b1;
          state_d  = StHoldoff;
`else
          state_d  = StIdle;
`endif
        end
      end
`ifdef KEY_EVT_HOLDOFF_EN
      StHoldoff:  if (ho_done) state_d = StHoClr;
      StHoClr:    state_d = StIdle;
`endif
      default:    state_d = StInitMask;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInitMask;
      cap_q   <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // readdata lags address by one cycle: CLR sees edge capture, LVL_SMP sees levels.
      if (state_q == StClr) begin
        cap_q <= readdata[KEY_W-1:0] & IRQ_MASK;
      end
      if (state_q == StLvlSmp) begin
        lvl_q <= readdata[KEY_W-1:0];
      end
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Gated by reset_n because the reset state (INIT_MASK) would otherwise decode a write.
  always_comb begin
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = KEY_OFS_DATA;
    writedata  = '0;
    if (reset_n) begin
      case (state_q)
        StInitMask: begin
          chipselect = 1'b1;
          write_n    = 1'b0;
          address    = KEY_OFS_MASK;
          writedata  = 32'(IRQ_MASK);
        end
        StInitClr, StClr: begin
          chipselect = 1'b1;
          write_n    = 1'b0;
          address    = KEY_OFS_EDGE;
        end
`ifdef KEY_EVT_HOLDOFF_EN
        StHoClr: begin
          chipselect = 1'b1;
          write_n    = 1'b0;
          address    = KEY_OFS_EDGE;
        end
`endif
        StRdCap: begin
          chipselect = 1'b1;
          address    = KEY_OFS_EDGE;
        end
        StRdLvl: begin
          chipselect = 1'b1;
          address    = KEY_OFS_DATA;
        end
        default: ;
      endcase
    end
  end

  assign event_valid = reset_n && (state_q == StEmit);
  assign event_keys  = cap_q;
  assign event_level = lvl_q;
  assign event_count = cnt_q;

endmodule

// File: tb/tb_de10_lite_key_event_master.sv
// Scoreboard bench: behavioural key PIO slave, expected-event queue, negedge monitor.
module tb_de10_lite_key_event_master;

  localparam int          Hold   = 1000;
  localparam int          CntW   = 3;
  localparam logic [3:0]  TbMask = 4'hF;
`ifdef KEY_EVT_HOLDOFF_EN
  localparam int          Settle = Hold + 30;
`else
  localparam int          Settle = 30;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      address;
  logic            chipselect;
  logic            write_n;
  logic [31:0]     writedata;
  logic [31:0]     readdata = '0;
  logic            irq;
  logic            event_valid;
  logic            event_ready;
  logic [3:0]      event_keys;
  logic [3:0]      event_level;
  logic [CntW-1:0] event_count;

  de10_lite_key_event_master #(
    .KEY_W         (4),
    .IRQ_MASK      (TbMask),
    .HOLDOFF_CYCLES(Hold),
    .CNT_W         (CntW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_keys (event_keys),
    .event_level(event_level),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model: registered readdata, clear write beats edge detect.
  logic [3:0] in_port;
  logic [3:0] in_prev  = 4'hF;
  logic [3:0] edge_cap = '0;
  logic [3:0] mask_reg = '0;
  logic       irq_force;

  always @(posedge clk) begin
    in_prev <= in_port;
    if (chipselect && !write_n && address == 2'd3) edge_cap <= '0;
    else edge_cap <= edge_cap | (in_prev & ~in_port);
    if (chipselect && !write_n && address == 2'd2) mask_reg <= writedata[3:0];
    if (chipselect && write_n) begin
      case (address)
        2'd0:    readdata <= {28'd0, in_port};
        2'd2:    readdata <= {28'd0, mask_reg};
        2'd3:    readdata <= {28'd0, edge_cap};
        default: readdata <= '0;
      endcase
    end else begin
      readdata <= '0;
    end
  end

  assign irq = (|(edge_cap & mask_reg)) | irq_force;

  typedef struct {
    logic [3:0] keys;
    logic [3:0] lvl;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pushed = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_access = 0;
  int   n_clr = 0;
  int   last_clr = -1;
  int   valid_cycles = 0;
  int   acc_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Expected event from the press alone: pressed keys masked, levels as held, running count.
  task automatic push_exp(input logic [3:0] pressed, input logic [3:0] level);
    exp_t e;
    e.keys = pressed & TbMask;
    e.lvl  = level;
    e.cnt  = pushed % (1 << CntW);
    pushed++;
    exp_q.push_back(e);
  endtask

  // Monitor: pops on each handshake and tracks bus activity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chipselect) n_access++;
      if (chipselect && !write_n && address == 2'd3) begin
        n_clr++;
        last_clr = cyc;
      end
      if (event_valid) valid_cycles++;
      if (event_valid && event_ready) begin
        acc_cyc = cyc;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: keys %b level %b, required no event", event_keys,
                   event_level);
        end else begin
          e = exp_q.pop_front();
          check("event_keys", 64'(event_keys), 64'(e.keys));
          check("event_level", 64'(event_level), 64'(e.lvl));
          check("event_count", 64'(event_count), 64'(e.cnt));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!event_valid && n < 50) begin
      tick();
      n++;
    end
    check(name, 64'(event_valid), 64'd1);
  endtask

  task automatic drain(input bit rnd, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      if (rnd) event_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    event_ready = 1'b1;
  endtask

  // Called just after reset release, before the first rising edge.
  task automatic check_init(input string tag);
    #1;
    check({tag, "_mask_wr"}, {28'd0, chipselect, write_n, address, writedata},
          {28'd0, 1'b1, 1'b0, 2'd2, 32'hF});
    tick();
    check({tag, "_clr_wr"}, {28'd0, chipselect, write_n, address, writedata},
          {28'd0, 1'b1, 1'b0, 2'd3, 32'h0});
    tick();
    check({tag, "_idle"}, {28'd0, chipselect, write_n, address, writedata},
          {28'd0, 1'b0, 1'b1, 2'd0, 32'h0});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ci, cv, a, a0, c0, v0;
    logic [3:0] s;

    reset_n     = 1'b0;
    event_ready = 1'b0;
    in_port     = 4'hF;
    irq_force   = 1'b0;
    repeat (3) tick();
    check("reset_values",
          {16'd0, address, chipselect, write_n, writedata, event_valid, event_keys, event_level,
           event_count},
          {16'd0, 2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 4'd0, 4'd0, 3'd0});
    @(negedge clk);
    #2 reset_n = 1'b1;
    check_init("init");

    // Single press of key 1 with latency check.
    settle(5);
    event_ready = 1'b1;
    push_exp(4'b0010, 4'b1101);
    in_port = 4'hD;
    ci = 0;
    while (!irq && ci < 10) begin
      tick();
      ci++;
    end
    ci = cyc;
    wait_valid("first_event_arrives");
    cv = cyc;
    check("irq_to_valid_latency", 64'(cv - ci), 64'd5);
    tick();
    check("valid_drops_after_accept", 64'(event_valid), 64'd0);
    tick();
    check("count_after_first", 64'(event_count), 64'd1);
    drain(0, "drain_first");
    in_port = 4'hF;
    settle(Settle);

    // Consumer stalls 100 cycles while key 2 joins key 0.
    event_ready = 1'b0;
    push_exp(4'b0001, 4'b1110);
    in_port = 4'hE;
    wait_valid("stall_event_arrives");
    a0 = n_access;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
`ifndef KEY_EVT_HOLDOFF_EN
        push_exp(4'b0100, 4'b1010);
`endif
        in_port = 4'hA;
      end
      tick();
    end
    check("no_access_while_stalled", 64'(n_access - a0), 64'd0);
    check("valid_held_while_stalled", 64'(event_valid), 64'd1);
    event_ready = 1'b1;
    drain(0, "drain_coalesced");
    in_port = 4'hF;
    settle(Settle);

    // Bounce after acceptance.
    push_exp(4'b0010, 4'b1101);
    in_port = 4'hD;
    drain(0, "drain_bounce_first");
    a  = acc_cyc;
    c0 = n_clr;
    v0 = valid_cycles;
    wait_cyc(a + 10);
    in_port = 4'hF;
    wait_cyc(a + 12);
`ifndef KEY_EVT_HOLDOFF_EN
    push_exp(4'b0010, 4'b1101);
`endif
    in_port = 4'hD;
    wait_cyc(a + 150);
    in_port = 4'hF;
    wait_cyc(a + 152);
`ifndef KEY_EVT_HOLDOFF_EN
    push_exp(4'b0010, 4'b1101);
`endif
    in_port = 4'hD;
    wait_cyc(a + 1100);
`ifdef KEY_EVT_HOLDOFF_EN
    check("holdoff_clear_writes", 64'(n_clr - c0), 64'd1);
    check("holdoff_clear_cycle", 64'(last_clr), 64'(a + 1001));
    check("holdoff_no_event", 64'(valid_cycles - v0), 64'd0);
`else
    check("bounce_clear_writes", 64'(n_clr - c0), 64'd2);
`endif
    check("bounce_events_consumed", 64'(exp_q.size()), 64'd0);
    in_port = 4'hF;
    settle(Settle);

    // Spurious irq with nothing captured.
    a0 = n_access;
    c0 = n_clr;
    v0 = valid_cycles;
    irq_force = 1'b1;
    tick();
    irq_force = 1'b0;
    settle(20);
    check("spurious_accesses", 64'(n_access - a0), 64'd3);
    check("spurious_clears", 64'(n_clr - c0), 64'd1);
    check("spurious_no_event", 64'(valid_cycles - v0), 64'd0);

    // Reset while an event is presented.
    event_ready = 1'b0;
    push_exp(4'b1000, 4'b0111);
    in_port = 4'h7;
    wait_valid("emit_before_reset");
    #2 reset_n = 1'b0;
    #1;
    check("reset_in_emit",
          {48'd0, event_valid, chipselect, write_n, event_count, event_keys, event_level},
          {48'd0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 4'd0});
    exp_q.delete();
    pushed = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    check_init("reinit");
    in_port = 4'hF;
    event_ready = 1'b1;
    settle(10);

    // Random multi-key presses with random back-pressure; count wraps modulo 8.
    for (int k = 0; k < 24; k++) begin
      s = 4'($urandom_range(1, 15));
      push_exp(s, ~s);
      in_port = ~s;
      drain(1, "drain_random");
      in_port = 4'hF;
      settle(Settle);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
